// File: rtl/uart_rx.sv
// uart_rx - asynchronous serial receiver (8N1, LSB first) feeding a
// valid/ready byte holding register, with framing-error and overrun pulses.
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1 and adds the
// PARITY_ERR output; the default build (macro undefined) is 8N1 only.
module uart_rx #(
    parameter int CLK_FREQ_HZ = 27000000,
    parameter int BAUD        = 115200,
    parameter int DIVISOR     = CLK_FREQ_HZ / BAUD
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXD,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
`ifdef UART_RX_PARITY_EN
    output logic       PARITY_ERR,
`endif
    output logic       BUSY
);

    // A bit time shorter than 4 clocks leaves no room for mid-bit sampling.
    generate
        if (DIVISOR < 4) begin : g_divisor_check
            $error("uart_rx: DIVISOR must be >= 4");
        end
    endgenerate

    localparam int CNT_W = $clog2(DIVISOR);
    localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL_M1 = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY
`endif
    } state_t;

    logic             r_sync1;
    logic             r_rxs;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shreg;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;
`ifdef UART_RX_PARITY_EN
    logic             r_par_bit;
    logic             r_parity_err;
`endif

    // Two-flop synchronizer; reset to the idle (high) line level.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= RXD;
            r_rxs   <= r_sync1;
        end
    end

    // Receive FSM, bit-time counter, shift register and holding register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            // NOTE: a consumer handshake clears the holding register here; a
            // delivery later in this block overrides it because the last
            // non-blocking assignment to a register in a cycle wins.
            if (r_valid && RX_READY) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!r_rxs) begin
                        r_cnt   <= CNT_HALF_M1;
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end else if (r_rxs) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt     <= CNT_FULL_M1;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end else begin
                        r_shreg   <= {r_rxs, r_shreg[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        r_cnt     <= CNT_FULL_M1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end else begin
                        r_par_bit <= r_rxs;
                        r_cnt     <= CNT_FULL_M1;
                        r_state   <= S_STOP;
                    end
                end
`endif

                S_STOP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end else if (!r_rxs) begin
                        // Low stop bit: drop the byte and wait out a break.
                        r_frame_err <= 1'b1;
                        r_state     <= S_WAIT_HIGH;
                    end else begin
                        r_state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{r_shreg, r_par_bit}) begin
                            r_parity_err <= 1'b1;
                        end else
`endif
                        if (!r_valid || RX_READY) begin
                            r_data  <= r_shreg;
                            r_valid <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end
                end

                S_WAIT_HIGH: begin
                    if (r_rxs) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign RX_DATA   = r_data;
    assign RX_VALID  = r_valid;
    assign FRAME_ERR = r_frame_err;
    assign OVERRUN   = r_overrun;
    assign BUSY      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign PARITY_ERR = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - directed bench for uart_rx at DIVISOR=16 with a byte scoreboard.
module tb_uart_rx;

    localparam int DIV = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC   = FRAME_BITS * DIV;
    // Nominal start-edge to RX_VALID latency.
    localparam int LAT_NOM     = 2 + DIV / 2 + (FRAME_BITS - 1) * DIV;
    // Rising edge (counted from the start-edge drive) that samples the stop bit:
    // 2 synchronizer edges, 1 idle-detect edge, DIV/2 start, (FRAME_BITS-1)*DIV bits.
    localparam int STOP_SAMPLE = 3 + DIV / 2 + (FRAME_BITS - 1) * DIV;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       RXD;
    logic       RX_READY;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       BUSY;
`ifdef UART_RX_PARITY_EN
    logic       PARITY_ERR;
    logic       tb_par_flip = 1'b0;
`endif

    always #5 CLK = ~CLK;

    uart_rx #(
        .CLK_FREQ_HZ(16),
        .BAUD       (1)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .RXD      (RXD),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .FRAME_ERR(FRAME_ERR),
        .OVERRUN  (OVERRUN),
`ifdef UART_RX_PARITY_EN
        .PARITY_ERR(PARITY_ERR),
`endif
        .BUSY     (BUSY)
    );

    int n_total = 0;
    int n_bad   = 0;
    logic [7:0] exp_q[$];

    // Pulse / edge counters sampled just after each rising edge.
    int n_ferr = 0, n_ovr = 0, n_vrise = 0, n_brise = 0, n_both = 0;
    int n_perr = 0;
    logic prev_v = 1'b0, prev_b = 1'b0;
    always @(posedge CLK) begin
        #1;
        if (FRAME_ERR) n_ferr++;
        if (OVERRUN) n_ovr++;
        if (FRAME_ERR && OVERRUN) n_both++;
        if (RX_VALID && !prev_v) n_vrise++;
        if (BUSY && !prev_b) n_brise++;
`ifdef UART_RX_PARITY_EN
        if (PARITY_ERR) n_perr++;
`endif
        prev_v = RX_VALID;
        prev_b = BUSY;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        RXD = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            tick(DIV);
        end
`ifdef UART_RX_PARITY_EN
        RXD = (^b) ^ tb_par_flip;
        tick(DIV);
`endif
        RXD = stop_bit;
        tick(DIV);
    endtask

    // Wait (bounded) for RX_VALID, then compare RX_DATA with the scoreboard head.
    task automatic pop_check(input string tag);
        int waited = 0;
        logic [7:0] e;
        while (!RX_VALID && waited < 400) begin
            tick(1);
            waited++;
        end
        check({tag, "_valid"}, RX_VALID, 1);
        check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, RX_DATA, e);
        end
    endtask

    task automatic consume(input string tag);
        RX_READY = 1'b1;
        tick(1);
        RX_READY = 1'b0;
        check({tag, "_cleared"}, RX_VALID, 0);
    endtask

    int lat;
    int s_f, s_o, s_v, s_b;
`ifdef UART_RX_PARITY_EN
    int s_p;
`endif

    initial begin
        RESET    = 1'b0;
        RXD      = 1'b1;
        RX_READY = 1'b0;
        tick(2);
        check("rst_data", RX_DATA, 8'h00);
        check("rst_valid", RX_VALID, 0);
        check("rst_ferr", FRAME_ERR, 0);
        check("rst_ovr", OVERRUN, 0);
        check("rst_busy", BUSY, 0);
`ifdef UART_RX_PARITY_EN
        check("rst_perr", PARITY_ERR, 0);
`endif
        RESET = 1'b1;
        tick(5);
        check("idle_busy", BUSY, 0);

        // Frame 0xA5 with the consumer stalled; measure latency.
        exp_q.push_back(8'hA5);
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (!RX_VALID && lat < 400) begin
                    tick(1);
                    lat++;
                end
            end
        join
        check("a5_latency_window", (lat >= LAT_NOM - 1) && (lat <= LAT_NOM + 1), 1);
        pop_check("a5");
        tick(20);
        check("a5_valid_held", RX_VALID, 1);
        check("a5_no_ferr", n_ferr, 0);
        check("a5_no_ovr", n_ovr, 0);
        consume("a5");
        check("a5_data_held", RX_DATA, 8'hA5);

        // Short low glitch: false start only.
        s_b = n_brise; s_v = n_vrise; s_f = n_ferr; s_o = n_ovr;
        RXD = 1'b0;
        tick(3);
        RXD = 1'b1;
        tick(30);
        check("glitch_busy_pulse", n_brise - s_b, 1);
        check("glitch_busy_low", BUSY, 0);
        check("glitch_no_valid", n_vrise - s_v, 0);
        check("glitch_no_ferr", n_ferr - s_f, 0);
        check("glitch_no_ovr", n_ovr - s_o, 0);

        // Bad stop bit followed by a held-low break, then a good frame.
        s_v = n_vrise; s_f = n_ferr; s_o = n_ovr;
        send_frame(8'h3C, 1'b0);
        tick(40);
        RXD = 1'b1;
        tick(10);
        check("brk_one_ferr", n_ferr - s_f, 1);
        check("brk_no_valid", n_vrise - s_v, 0);
        check("brk_no_ovr", n_ovr - s_o, 0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        pop_check("brk_55");
        check("brk_still_one_ferr", n_ferr - s_f, 1);
        consume("brk_55");

        // Back-to-back 0x11, 0x22 with consumer stalled: 0x22 overruns.
        s_v = n_vrise; s_f = n_ferr; s_o = n_ovr;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(5);
        check("ovr_one_pulse", n_ovr - s_o, 1);
        check("ovr_one_valid", n_vrise - s_v, 1);
        check("ovr_no_ferr", n_ferr - s_f, 0);
        pop_check("ovr_11");
        consume("ovr_11");

        // Same pair, consumer ready exactly on 0x22's stop-sample edge.
        s_v = n_vrise; s_o = n_ovr;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            begin
                tick(FRAME_CYC + STOP_SAMPLE - 1);
                pop_check("swap_11");
                RX_READY = 1'b1;
                tick(1);
                RX_READY = 1'b0;
            end
        join
        check("swap_valid_kept", RX_VALID, 1);
        pop_check("swap_22");
        check("swap_no_ovr", n_ovr - s_o, 0);
        check("swap_single_rise", n_vrise - s_v, 1);

        // Asynchronous reset during data bit 4 of 0x7E (0x22 left unread).
        fork
            send_frame(8'h7E, 1'b1);
            begin
                tick(DIV * 5 + DIV / 2);
                check("rstmid_busy_before", BUSY, 1);
                check("rstmid_valid_before", RX_VALID, 1);
                #2;
                RESET = 1'b0;
                #1;
                check("rstmid_data", RX_DATA, 8'h00);
                check("rstmid_valid", RX_VALID, 0);
                check("rstmid_busy", BUSY, 0);
                check("rstmid_ferr", FRAME_ERR, 0);
                check("rstmid_ovr", OVERRUN, 0);
            end
        join
        tick(5);
        RESET = 1'b1;
        tick(10);
        check("rstmid_idle_busy", BUSY, 0);
        s_v = n_vrise;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        pop_check("post_rst_81");
        check("post_rst_one_valid", n_vrise - s_v, 1);
        consume("post_rst_81");

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1.
        s_p = n_perr; s_v = n_vrise; s_o = n_ovr;
        tb_par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        tb_par_flip = 1'b0;
        tick(5);
        check("par_bad_pulse", n_perr - s_p, 1);
        check("par_bad_no_valid", n_vrise - s_v, 0);
        check("par_bad_no_ovr", n_ovr - s_o, 0);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        pop_check("par_good_07");
        check("par_good_no_perr", n_perr - s_p, 1);
        consume("par_good_07");
`endif

        check("sb_drained", exp_q.size(), 0);
        check("no_ferr_ovr_overlap", n_both, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
